// File: rtl/fifo_ctrl_zxn.sv
// fifo_ctrl_zxn: first-word-fall-through FIFO controller for an external
// distributed dual-port RAM (synchronous write, asynchronous read).
// Owns the RAM write port and read address, and adds a one-entry output
// register so rd_data is always a flop.
//
// Ports:
//   clocka, reset            single clock, synchronous active-high reset
//   flush                    synchronous clear of FIFO state (RAM untouched)
//   wr_data/wr_valid/wr_ready   producer handshake
//   rd_data/rd_valid/rd_ready   consumer handshake (rd_data registered)
//   count                    words held (RAM + output register)
//   almost_full              count >= AFULL_LEVEL
//   overflow                 sticky: write attempted while wr_ready=0
//   ram_address_a/ram_data_a/ram_wren_a   RAM write port
//   ram_address_dpra/ram_dpo              RAM async read port
module fifo_ctrl_zxn #(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned ADDRWIDTH   = 4,
  parameter int unsigned AFULL_LEVEL = 2**ADDRWIDTH - 2
) (
  input  logic                 clocka,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDRWIDTH:0]   count,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [ADDRWIDTH-1:0] ram_address_a,
  output logic [DATAWIDTH-1:0] ram_data_a,
  output logic                 ram_wren_a,
  output logic [ADDRWIDTH-1:0] ram_address_dpra,
  input  logic [DATAWIDTH-1:0] ram_dpo
);

  localparam int unsigned PW = ADDRWIDTH + 1;

  logic [PW-1:0]        wp_q, wp_d;
  logic [PW-1:0]        rp_q, rp_d;
  logic [PW-1:0]        count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 almost_full_q, almost_full_d;
  logic                 overflow_q, overflow_d;

  logic ram_empty;
  logic ram_full;
  logic clear;
  logic wr_accept;
  logic load;

  // RAM occupancy flags from the wrap-bit pointers
  always_comb begin
    ram_empty = (wp_q == rp_q);
    ram_full  = (wp_q[ADDRWIDTH-1:0] == rp_q[ADDRWIDTH-1:0]) &&
                (wp_q[ADDRWIDTH] != rp_q[ADDRWIDTH]);
  end

  // Handshake qualifiers; a clear cycle never writes the RAM
  always_comb begin
    clear     = reset | flush;
    wr_accept = wr_valid & ~ram_full & ~clear;
    // Output stage refills when empty or being drained this cycle
    load      = ~ram_empty & (~rd_valid_q | rd_ready);
  end

  // Next-state computation
  always_comb begin
    wp_d          = wp_q + PW'(wr_accept);
    rp_d          = rp_q + PW'(load);
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    overflow_d    = overflow_q | (wr_valid & ram_full);

    if (load) begin
      rd_data_d  = ram_dpo;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    count_d       = (wp_d - rp_d) + PW'(rd_valid_d);
    // Derived from next-state count so the flag tracks count exactly
    almost_full_d = (32'(count_d) >= AFULL_LEVEL);

    if (flush) begin
      wp_d          = '0;
      rp_d          = '0;
      rd_valid_d    = 1'b0;
      count_d       = '0;
      almost_full_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clocka) begin
    if (reset) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  // Output mapping; wr_ready depends on registered pointers only
  always_comb begin
    wr_ready         = ~ram_full;
    rd_data          = rd_data_q;
    rd_valid         = rd_valid_q;
    count            = count_q;
    almost_full      = almost_full_q;
    overflow         = overflow_q;
    ram_address_a    = wp_q[ADDRWIDTH-1:0];
    ram_data_a       = wr_data;
    ram_wren_a       = wr_accept;
    ram_address_dpra = rp_q[ADDRWIDTH-1:0];
  end

endmodule

// File: tb/tb_fifo_ctrl_zxn.sv
// Directed bench for fifo_ctrl_zxn with a behavioural RAM and a
// scoreboard queue of expected read words.
module tb_fifo_ctrl_zxn;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;
  logic [3:0] ram_address_a;
  logic [7:0] ram_data_a;
  logic       ram_wren_a;
  logic [3:0] ram_address_dpra;
  logic [7:0] ram_dpo;

  logic [7:0] mem [16];

  int   passed;
  int   total;
  int   popped;
  logic accepted;
  logic [7:0] sb [$];

  fifo_ctrl_zxn #(
    .DATAWIDTH(8),
    .ADDRWIDTH(4),
    .AFULL_LEVEL(14)
  ) dut (
    .clocka          (clk),
    .reset           (reset),
    .flush           (flush),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .count           (count),
    .almost_full     (almost_full),
    .overflow        (overflow),
    .ram_address_a   (ram_address_a),
    .ram_data_a      (ram_data_a),
    .ram_wren_a      (ram_wren_a),
    .ram_address_dpra(ram_address_dpra),
    .ram_dpo         (ram_dpo)
  );

  // Distributed RAM: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
  end
  assign ram_dpo = mem[ram_address_dpra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, score handshakes mid-cycle, end #1 past the edge
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    logic [7:0] exp_w;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    accepted = wv && wr_ready && !fl;
    if (accepted) sb.push_back(wd);
    if (fl) chk("wren_in_flush", 32'(ram_wren_a), 32'd0);
    if (rd_valid && rd_ready && !fl) begin
      total++;
      assert (sb.size() != 0) passed++;
      else $error("FAIL spurious_output observed=0x%0h expected=none", rd_data);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        popped++;
        chk("rd_data_order", 32'(rd_data), 32'(exp_w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int n;
    logic wv;
    logic rr;
    passed   = 0;
    total    = 0;
    popped   = 0;
    accepted = 1'b0;
    reset    = 1'b1;
    flush    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    rd_ready = 1'b0;

    // Reset held two cycles with a write offered
    @(negedge clk);
    chk("wren_in_reset", 32'(ram_wren_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    wr_valid = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Single word: two-edge latency, then drained
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("sw_e0_rd_valid", 32'(rd_valid), 32'd0);
    chk("sw_e0_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sw_e1_rd_valid", 32'(rd_valid), 32'd1);
    chk("sw_e1_rd_data", 32'(rd_data), 32'hA5);
    chk("sw_e1_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sw_e2_rd_valid", 32'(rd_valid), 32'd0);
    chk("sw_e2_count", 32'(count), 32'd0);
    chk("sw_popped", 32'(popped), 32'd1);

    // Fill without reads: 17 accepted, 18th dropped
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < 17) begin
        chk("fill_count", 32'(count), 32'(i + 1));
        chk("fill_almost_full", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      end
    end
    chk("full_count", 32'(count), 32'd17);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_sb_size", 32'(sb.size()), 32'd17);

    // Full: read and write together, write refused
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullrw_count", 32'(count), 32'd16);
    chk("fullrw_wr_ready", 32'(wr_ready), 32'd1);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    chk("fullrw_accept_count", 32'(count), 32'd17);
    chk("fullrw_sb_size", 32'(sb.size()), 32'd17);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_rd_valid", 32'(rd_valid), 32'd0);

    // Clear the sticky overflow before streaming
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_overflow", 32'(overflow), 32'd0);

    // Streaming 40 words across the pointer wrap with a random consumer
    popped = 0;
    nxt    = 0;
    n      = 0;
    while ((nxt < 40 || sb.size() != 0) && n < 400) begin
      wv = (nxt < 40) && wr_ready;
      rr = 1'($urandom_range(0, 1));
      step(wv, 8'(nxt), rr, 1'b0);
      if (accepted) nxt++;
      n++;
    end
    chk("stream_sent", 32'(nxt), 32'd40);
    chk("stream_popped", 32'(popped), 32'd40);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);
    chk("stream_overflow", 32'(overflow), 32'd0);
    chk("stream_count", 32'(count), 32'd0);

    // Flush with 9 words held and a write offered
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd9);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    sb.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
    chk("flush_overflow", 32'(overflow), 32'd0);
    chk("flush_wr_ready", 32'(wr_ready), 32'd1);
    chk("flush_almost_full", 32'(almost_full), 32'd0);
    popped = 0;
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_rd_valid", 32'(rd_valid), 32'd1);
    chk("post_flush_rd_data", 32'(rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_popped", 32'(popped), 32'd1);
    chk("post_flush_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_zxn.md
# fifo_ctrl_zxn

Synchronous FIFO controller that sits directly upstream of the distributed dual-port RAM (`sdpram_zxN`) and owns its write port and read-address port. It turns the bare RAM into a first-word-fall-through FIFO with a valid/ready handshake on both sides, an occupancy count, an almost-full flag, and a sticky overflow flag. It is used wherever a producer in one video or peripheral stage must hand data to a consumer at an uneven rate on the same clock, for example copper/DMA command queues.

## Interface
Parameters:
- `DATAWIDTH`, default 8: FIFO word width; must match the RAM's `DATAWIDTH`.
- `ADDRWIDTH`, default 4: RAM depth is 2**ADDRWIDTH words; must match the RAM's `ADDRWIDTH`.
- `AFULL_LEVEL`, default 2**ADDRWIDTH-2: `almost_full` asserts when `count` >= this value.

Ports:
- `clocka`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of the FIFO contents.
- `wr_data`  in  DATAWIDTH  producer data.
- `wr_valid`  in  1  producer offers `wr_data`.
- `wr_ready`  out  1  FIFO can accept a word this cycle.
- `rd_data`  out  DATAWIDTH  head word; this is a register.
- `rd_valid`  out  1  `rd_data` holds a valid word.
- `rd_ready`  in  1  consumer takes `rd_data`.
- `count`  out  ADDRWIDTH+1  total words held: RAM words plus the output register.
- `almost_full`  out  1  `count` >= `AFULL_LEVEL`.
- `overflow`  out  1  sticky flag: a write was attempted while `wr_ready`=0.
- `ram_address_a`  out  ADDRWIDTH  goes to RAM `address_a`.
- `ram_data_a`  out  DATAWIDTH  goes to RAM `data_a`.
- `ram_wren_a`  out  1  goes to RAM `wren_a`.
- `ram_address_dpra`  out  ADDRWIDTH  goes to RAM `address_dpra`.
- `ram_dpo`  in  DATAWIDTH  comes from RAM `dpo`; this is an asynchronous read.

## Operation
Pointers:
- `wp` and `rp` are each ADDRWIDTH+1 bits wide. The low ADDRWIDTH bits address the RAM; the MSB is the wrap bit.
- `ram_count` = `wp` - `rp`, computed modulo 2**(ADDRWIDTH+1).
- `ram_empty` = (`wp` == `rp`).
- `ram_full` = low bits equal and MSBs differ.

Write side:
- `wr_ready` = !`ram_full`. It depends only on registered state, with no combinational path from `rd_ready`.
- The write port is driven directly: `ram_address_a` = `wp`[ADDRWIDTH-1:0], `ram_data_a` = `wr_data`, `ram_wren_a` = `wr_valid` & `wr_ready`.
- A write is accepted when `wr_valid` & `wr_ready`. On acceptance, `wp` increments at the edge.
- When `wr_valid` & !`wr_ready`, the word is dropped, `overflow` sets, and `wp` is unchanged.

Read side (one-entry output stage):
- `ram_address_dpra` = `rp`[ADDRWIDTH-1:0].
- `load` = !`ram_empty` & (!`rd_valid` | `rd_ready`).
- On `load`: `rd_data` <= `ram_dpo`, `rd_valid` <= 1, and `rp` increments.
- On `rd_valid` & `rd_ready` & !`load`: `rd_valid` <= 0 and `rd_data` holds its value.
- `rd_data` changes only on `load`.

Flags:
- `count` = `ram_count` + `rd_valid`, registered. Its maximum is 2**ADDRWIDTH+1.
- `almost_full` is registered and derived from the next-state `count`, so it matches `count` every cycle.

Priority in a single cycle: `reset` > `flush` > normal operation.
- `flush` clears `wp`, `rp`, `rd_valid`, `count`, `almost_full` and `overflow`.
- While `flush` is high, `ram_wren_a` is forced to 0.
- RAM contents are not cleared by `flush`.
- `reset` has the same effect as `flush`.

## Timing
- Reset values: `wp`=`rp`=0, `rd_valid`=0, `rd_data`=0, `count`=0, `almost_full`=0 (valid for `AFULL_LEVEL`>0), `overflow`=0. Consequently `wr_ready`=1 and `ram_wren_a`=0 (while `reset` is high).
- Write-to-read latency into an empty FIFO:
  - Word accepted at edge E0.
  - RAM holds it after E0; `ram_dpo` is valid during the next cycle.
  - The output register loads at E1, so `rd_valid`=1 after E1 (2 edges).
- Sustained throughput: 1 word per cycle in and 1 word per cycle out with no bubbles once `rd_valid`=1 and `ram_count`>0.
- Simultaneous write and `load` with the RAM full:
  - The write is refused, because `wr_ready` was 0 at the start of the cycle.
  - `wr_ready` returns to 1 on the next cycle.
- Simultaneous write and `load` with 0 < `ram_count` < 2**ADDRWIDTH: both occur, and `ram_count` is unchanged.
- Same-address hazard: the write and the read address are never equal while `ram_count`>0 and not full, so `ram_dpo` is never the word being written that cycle.
- Pointer wrap: the low pointer bits roll over from 2**ADDRWIDTH-1 to 0 and the MSB toggles. There is no data loss across the wrap.
- `flush` or `reset` mid-stream: the next cycle shows the empty state. A write presented in the flush cycle is discarded and does not set `overflow`.

## Test plan
- Reset with ADDRWIDTH=4 and DATAWIDTH=8: hold `reset` 2 cycles, then check `count`=0, `rd_valid`=0, `wr_ready`=1, `overflow`=0, `ram_wren_a`=0.
- Single word:
  - Stimulus: write 0xA5 at E0, with `rd_ready`=1.
  - Response: after E1, `rd_valid`=1 and `rd_data`=0xA5. After E2, `rd_valid`=0 and `count`=0.
- Fill without reads (`rd_ready`=0):
  - Stimulus: write 0x00..0x11 (18 words).
  - Response: 17 words accepted (16 in RAM plus 1 in the output register). After E0 of the 17th accept, `count`=17.
  - Response: `wr_ready`=0, `overflow`=1 on the 18th attempt, and `almost_full`=1 from `count`>=14.
- Streaming across wrap: write 40 incrementing words while `rd_ready` toggles pseudo-randomly. Output order must be 0..39 exactly, with no duplicates or gaps.
- Full plus simultaneous read/write: with the FIFO full, pulse `rd_ready` and `wr_valid` in the same cycle. The write is refused that cycle and `count` drops to 16. On the next cycle `wr_ready`=1 and the write is accepted.
- Flush during traffic: with `count`=9, assert `flush` together with `wr_valid`. Next cycle `count`=0, `rd_valid`=0, `overflow`=0. A subsequent write of 0x3C emerges as the first read.
